trap_seq: RTL
=============

# trap_seq

Trap/return sequencer for the amber pipeline. It accepts software-interrupt, fault, interrupt and `SRET` requests from the execute stage and external logic. For each accepted event it drives pipeline flush/stall, writes the link register (LR) and redirects fetch. It also owns the kernel-mode bit. `stg_ex` still computes the `SRET` branch target; `trap_seq` sequences the surrounding control so traps and returns commit atomically.

## Interface

Parameters:
- `ADDR_W`, 48: address width; matches `HBIT_ADDR+1`.
- `VEC_SWI`, 48'h0000_0000_0010: SWI handler vector.
- `VEC_IRQ`, 48'h0000_0000_0020: IRQ handler vector.
- `VEC_FAULT`, 48'h0000_0000_0030: privilege-fault handler vector.

Ports:
- `iw_clk`  in  1  clock; all state updates on rising edge.
- `iw_rst`  in  1  synchronous, active-high reset.
- `iw_swi_req`  in  1  one-cycle pulse; EX holds an SWI instruction.
- `iw_sret_req`  in  1  one-cycle pulse; EX holds an `SRET`.
- `iw_irq`  in  1  level interrupt request; held until serviced.
- `iw_ex_pc`  in  ADDR_W  PC of the instruction currently in EX.
- `iw_lr_val`  in  ADDR_W  current LR contents (the `SRET` target).
- `iw_mem_busy`  in  1  downstream stages still draining.
- `ow_flush`  out  1  flush IF/ID/EX.
- `ow_stall`  out  1  stall fetch/decode.
- `ow_redirect`  out  1  load `ow_redirect_pc` into fetch PC.
- `ow_redirect_pc`  out  ADDR_W  redirect target.
- `ow_lr_we`  out  1  write LR.
- `ow_lr_val`  out  ADDR_W  LR write data.
- `ow_kmode`  out  1  kernel mode (1 = kernel).
- `ow_cause`  out  2  last trap cause: 0 none, 1 SWI, 2 IRQ, 3 fault.
- `ow_busy`  out  1  state is not `IDLE`.

## Operation

- All outputs are registered. States: `IDLE`, `DRAIN`, `SAVE`, `VECTOR`, `RET`.
- Request sampling happens only in `IDLE`. Priority is `sret_req` > `swi_req` > `irq`. Requests seen in any other state are ignored; a held `iw_irq` is re-sampled on return to `IDLE`.
- Accepting `sret_req` with `kmode=1`:
  - latch `iw_lr_val` into `ret_pc`;
  - go to `RET`.
- Accepting `sret_req` with `kmode=0` (privilege fault):
  - set cause=3 and `ret_pc=iw_ex_pc`;
  - go to `DRAIN`.
- Accepting `swi_req` (either mode):
  - set cause=1 and `ret_pc=iw_ex_pc+1` (mod 2^ADDR_W, so 48'hFFFF_FFFF_FFFF wraps to 0);
  - go to `DRAIN`.
  - A nested SWI in kernel mode overwrites LR; this is intended.
- Accepting `irq`: only when `kmode=0`. Set cause=2 and `ret_pc=iw_ex_pc` (EX instruction is re-executed); go to `DRAIN`.
- `DRAIN`: `ow_flush=1`, `ow_stall=1`. Stay while `iw_mem_busy=1`; go to `SAVE` on the first cycle it reads 0.
- `SAVE`: `ow_lr_we=1`, `ow_lr_val=ret_pc`, `ow_stall=1`; go to `VECTOR`.
- `VECTOR`:
  - `ow_redirect=1`, `ow_redirect_pc` = vector selected by cause;
  - `kmode` is set to 1, visible from the next cycle;
  - go to `IDLE`.
- `RET`:
  - `ow_flush=1`, `ow_redirect=1`, `ow_redirect_pc=ret_pc`;
  - `kmode` is cleared, visible from the next cycle;
  - `ow_cause` is left unchanged;
  - go to `IDLE`.
- Pulse outputs (`ow_flush`, `ow_stall`, `ow_redirect`, `ow_lr_we`) are 0 in every state not listed above.
- `ow_redirect_pc` and `ow_lr_val` hold their last value when not qualified.

## Timing

- Reset: state `IDLE`. All outputs reset to 0: `ow_flush`, `ow_stall`, `ow_redirect`, `ow_lr_we`, `ow_kmode`, `ow_busy`, `ow_cause=0`, `ow_redirect_pc=0`, `ow_lr_val=0`.
- Reset asserted in any state aborts the sequence. The LR write and redirect are not issued, and kmode returns to 0.
- Trap latency with `mem_busy=0`:
  - request sampled at edge E;
  - `ow_flush` high E+1..E+2 (one cycle in `DRAIN`), then `ow_lr_we` high for one cycle, then `ow_redirect` high for one cycle;
  - `ow_kmode=1` and `ow_busy=0` from the following cycle.
- Each cycle of `mem_busy=1` in `DRAIN` adds exactly one cycle.
- `SRET` latency: `ow_redirect` and `ow_flush` are high the cycle after the accept edge. `ow_kmode=0` the cycle after that.
- `ow_busy` is high in every cycle where state ≠ `IDLE`.
- Back-to-back: a request present on the first `IDLE` cycle after `VECTOR`/`RET` is accepted normally, giving zero idle gap.

## Test plan

- **SWI basic.** User mode, `ex_pc=48'h200`, `swi_req` pulse, `mem_busy=0` → flush 1 cycle, then `lr_we` with `lr_val=48'h201`, then redirect to 48'h10; then `kmode=1`, `cause=1`.
- **SRET.** After SWI, `lr_val=48'h0ABCDEF0`, `sret_req` pulse → next cycle redirect=1, flush=1, `redirect_pc=48'h0ABCDEF0`; then `kmode=0` and no `lr_we` at any point.
- **Privilege fault.** User mode, `sret_req`, `ex_pc=48'h300` → LR written 48'h300, redirect to 48'h30, `cause=3`, `kmode=1`.
- **IRQ masking and priority.**
  - `irq` held high while in kernel mode → no accept; after `SRET` completes, IRQ is taken with LR=`ex_pc` and redirect 48'h20.
  - `swi_req` and `irq` in the same cycle → SWI wins.
- **Drain and wrap.** `mem_busy` high 3 cycles in `DRAIN` → `flush` high 4 cycles, `lr_we` delayed by 3 cycles. SWI at `ex_pc=48'hFFFF_FFFF_FFFF` → `lr_val=0`.
- **Reset mid-trap.** `iw_rst` asserted in `SAVE` → next cycle all outputs 0, state `IDLE`, no redirect issued.

Source files
------------

// File: rtl/trap_seq.sv
// Trap/return sequencer: drains the pipeline, writes LR and redirects fetch for
// SWI, IRQ and privilege faults, and sequences SRET. It also owns the kernel-mode bit.
module trap_seq #(
   parameter int                ADDR_W    = 48,
   parameter logic [ADDR_W-1:0] VEC_SWI   = 48'h0000_0000_0010,
   parameter logic [ADDR_W-1:0] VEC_IRQ   = 48'h0000_0000_0020,
   parameter logic [ADDR_W-1:0] VEC_FAULT = 48'h0000_0000_0030
) (
   input  logic              iw_clk,
   input  logic              iw_rst,
   input  logic              iw_swi_req,
   input  logic              iw_sret_req,
   input  logic              iw_irq,
   input  logic [ADDR_W-1:0] iw_ex_pc,
   input  logic [ADDR_W-1:0] iw_lr_val,
   input  logic              iw_mem_busy,
   output logic              ow_flush,
   output logic              ow_stall,
   output logic              ow_redirect,
   output logic [ADDR_W-1:0] ow_redirect_pc,
   output logic              ow_lr_we,
   output logic [ADDR_W-1:0] ow_lr_val,
   output logic              ow_kmode,
   output logic [1:0]        ow_cause,
   output logic              ow_busy
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_SAVE   = 3'd2,
      ST_VECTOR = 3'd3,
      ST_RET    = 3'd4
   } state_t;

   localparam logic [1:0] CAUSE_NONE  = 2'd0;
   localparam logic [1:0] CAUSE_SWI   = 2'd1;
   localparam logic [1:0] CAUSE_IRQ   = 2'd2;
   localparam logic [1:0] CAUSE_FAULT = 2'd3;

   localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PC_ZERO = {ADDR_W{1'b0}};

   state_t            state_r, state_nxt_s;
   logic [ADDR_W-1:0] ret_pc_r, ret_pc_nxt_s;
   logic [1:0]        cause_r, cause_nxt_s;
   logic              kmode_r, kmode_nxt_s;
   logic              flush_r, flush_nxt_s;
   logic              stall_r, stall_nxt_s;
   logic              redirect_r, redirect_nxt_s;
   logic              lr_we_r, lr_we_nxt_s;
   logic              busy_r, busy_nxt_s;
   logic [ADDR_W-1:0] redirect_pc_r, redirect_pc_nxt_s;
   logic [ADDR_W-1:0] lr_val_r, lr_val_nxt_s;

   function automatic logic [ADDR_W-1:0] vec_sel(input logic [1:0] cause);
      logic [ADDR_W-1:0] vec;
      case (cause)
         CAUSE_SWI:   vec = VEC_SWI;
         CAUSE_IRQ:   vec = VEC_IRQ;
         CAUSE_FAULT: vec = VEC_FAULT;
         default:     vec = PC_ZERO;
      endcase
      return vec;
   endfunction

   // State and registered-output update; reset aborts any sequence in flight
   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         state_r       <= ST_IDLE;
         ret_pc_r      <= PC_ZERO;
         cause_r       <= CAUSE_NONE;
         kmode_r       <= 1'b0;
         flush_r       <= 1'b0;
         stall_r       <= 1'b0;
         redirect_r    <= 1'b0;
         lr_we_r       <= 1'b0;
         busy_r        <= 1'b0;
         redirect_pc_r <= PC_ZERO;
         lr_val_r      <= PC_ZERO;
      end else begin
         state_r       <= state_nxt_s;
         ret_pc_r      <= ret_pc_nxt_s;
         cause_r       <= cause_nxt_s;
         kmode_r       <= kmode_nxt_s;
         flush_r       <= flush_nxt_s;
         stall_r       <= stall_nxt_s;
         redirect_r    <= redirect_nxt_s;
         lr_we_r       <= lr_we_nxt_s;
         busy_r        <= busy_nxt_s;
         redirect_pc_r <= redirect_pc_nxt_s;
         lr_val_r      <= lr_val_nxt_s;
      end
   end

   // Next-state logic: requests are sampled only in IDLE, SRET > SWI > IRQ
   always_comb begin
      state_nxt_s  = state_r;
      ret_pc_nxt_s = ret_pc_r;
      cause_nxt_s  = cause_r;
      kmode_nxt_s  = kmode_r;
      case (state_r)
         ST_IDLE: begin
            if (iw_sret_req) begin
               if (kmode_r) begin
                  ret_pc_nxt_s = iw_lr_val;
                  state_nxt_s  = ST_RET;
               end else begin
                  cause_nxt_s  = CAUSE_FAULT;
                  ret_pc_nxt_s = iw_ex_pc;
                  state_nxt_s  = ST_DRAIN;
               end
            end else if (iw_swi_req) begin
               cause_nxt_s  = CAUSE_SWI;
               ret_pc_nxt_s = iw_ex_pc + PC_ONE;
               state_nxt_s  = ST_DRAIN;
            end else if (iw_irq && !kmode_r) begin
               // interrupted instruction is re-executed on return
               cause_nxt_s  = CAUSE_IRQ;
               ret_pc_nxt_s = iw_ex_pc;
               state_nxt_s  = ST_DRAIN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (iw_mem_busy) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_SAVE;
            end
         end
         ST_SAVE: begin
            state_nxt_s = ST_VECTOR;
         end
         ST_VECTOR: begin
            kmode_nxt_s = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         ST_RET: begin
            kmode_nxt_s = 1'b0;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output logic: decoded from the upcoming state so outputs are registered yet state-aligned
   always_comb begin
      flush_nxt_s       = (state_nxt_s == ST_DRAIN) || (state_nxt_s == ST_RET);
      stall_nxt_s       = (state_nxt_s == ST_DRAIN) || (state_nxt_s == ST_SAVE);
      redirect_nxt_s    = (state_nxt_s == ST_VECTOR) || (state_nxt_s == ST_RET);
      lr_we_nxt_s       = (state_nxt_s == ST_SAVE);
      busy_nxt_s        = (state_nxt_s != ST_IDLE);
      redirect_pc_nxt_s = redirect_pc_r;
      lr_val_nxt_s      = lr_val_r;
      case (state_nxt_s)
         ST_SAVE:   lr_val_nxt_s      = ret_pc_r;
         ST_VECTOR: redirect_pc_nxt_s = vec_sel(cause_r);
         ST_RET:    redirect_pc_nxt_s = ret_pc_nxt_s;
         default:   lr_val_nxt_s      = lr_val_r;
      endcase
   end

   assign ow_flush       = flush_r;
   assign ow_stall       = stall_r;
   assign ow_redirect    = redirect_r;
   assign ow_redirect_pc = redirect_pc_r;
   assign ow_lr_we       = lr_we_r;
   assign ow_lr_val      = lr_val_r;
   assign ow_kmode       = kmode_r;
   assign ow_cause       = cause_r;
   assign ow_busy        = busy_r;

endmodule
